lane_tone_scheduler: RTL and testbench

- Sound-effect scheduler that drives the 8-bit `audio_data` input of the team's PWM audio output stage.
- Accepts tone requests from NUM_REQ requesters (one per game lane / UI source) and allocates them onto NUM_VOICES square-wave voices. When all voices are busy, it steals the voice closest to finishing.
- Mixes the active voices into one unsigned 8-bit sample, updated once per PWM period (SAMPLE_DIV clocks), so each PWM cycle sees a stable duty value.

---
 rtl/lane_tone_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_lane_tone_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lane_tone_scheduler.sv
// Tone scheduler: arbitrates lane sound requests onto square-wave voices and
// mixes them into one 8-bit sample per PWM period.
module lane_tone_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int NUM_VOICES  = 2,
    parameter int SAMPLE_DIV  = 256,
    parameter int DUR_SAMPLES = 2048,
    parameter int AMP         = 48,
    parameter int HP_W        = 12
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [NUM_REQ*HP_W-1:0] half_period_i,
    output logic [NUM_REQ-1:0]      req_ack_o,
    output logic [NUM_REQ-1:0]      req_err_o,
    output logic                    voice_steal_o,
    output logic [NUM_VOICES-1:0]   voice_active_o,
    output logic                    sample_tick_o,
    output logic [7:0]              audio_data_o
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int RW = $clog2(DUR_SAMPLES + 1);
    localparam int SW = $clog2(256 + NUM_VOICES * AMP) + 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [RW-1:0] DUR_LOAD = RW'(DUR_SAMPLES);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_VOICES-1:0] active_q, active_d;
    logic [NUM_VOICES-1:0] level_q, level_d;
    logic [HP_W-1:0]       hp_q    [NUM_VOICES];
    logic [HP_W-1:0]       hp_d    [NUM_VOICES];
    logic [HP_W-1:0]       phase_q [NUM_VOICES];
    logic [HP_W-1:0]       phase_d [NUM_VOICES];
    logic [RW-1:0]         rem_q   [NUM_VOICES];
    logic [RW-1:0]         rem_d   [NUM_VOICES];
    logic [7:0]            audio_q, audio_d;

    logic                  tick_s;
    logic                  win_valid_s;
    logic [NUM_REQ-1:0]    win_oh_s;
    logic [HP_W-1:0]       hp_win_s;
    logic                  accept_s;
    logic                  reject_s;
    logic                  free_found_s;
    logic [VW-1:0]         free_idx_s;
    logic [VW-1:0]         steal_idx_s;
    logic [RW-1:0]         min_rem_s;
    logic [VW-1:0]         alloc_idx_s;
    logic [NUM_VOICES-1:0] load_s;
    logic [SW-1:0]         sum_s;
    logic [7:0]            mix_s;

    assign tick_s = (cnt_q == CNT_LAST);

    // Sample-tick divider
    always_comb begin
        if (tick_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Fixed-priority winner: lowest asserted request; silenced while in reset
    always_comb begin
        win_valid_s = 1'b0;
        win_oh_s    = '0;
        hp_win_s    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i] && !reset_i) begin
                win_valid_s = 1'b1;
                win_oh_s    = NUM_REQ'(1) << i;
                hp_win_s    = half_period_i[i*HP_W +: HP_W];
            end else begin
                win_valid_s = win_valid_s;
            end
        end
        accept_s = win_valid_s && (hp_win_s != '0);
        reject_s = win_valid_s && (hp_win_s == '0);
    end

    // Voice choice: first idle voice, otherwise the one closest to finishing
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!active_q[v]) begin
                free_found_s = 1'b1;
                free_idx_s   = VW'(v);
            end else begin
                free_found_s = free_found_s;
            end
        end
        steal_idx_s = '0;
        min_rem_s   = rem_q[0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (rem_q[v] < min_rem_s) begin
                steal_idx_s = VW'(v);
                min_rem_s   = rem_q[v];
            end else begin
                min_rem_s = min_rem_s;
            end
        end
        if (free_found_s) begin
            alloc_idx_s = free_idx_s;
        end else begin
            alloc_idx_s = steal_idx_s;
        end
        if (accept_s) begin
            load_s = NUM_VOICES'(1) << alloc_idx_s;
        end else begin
            load_s = '0;
        end
    end

    // Voice next state: a load always wins over the tick update
    always_comb begin
        active_d = active_q;
        level_d  = level_q;
        for (int v = 0; v < NUM_VOICES; v++) begin
            hp_d[v]    = hp_q[v];
            phase_d[v] = phase_q[v];
            rem_d[v]   = rem_q[v];
            if (load_s[v]) begin
                active_d[v] = 1'b1;
                level_d[v]  = 1'b1;
                hp_d[v]     = hp_win_s;
                phase_d[v]  = '0;
                rem_d[v]    = DUR_LOAD;
            end else if (tick_s && active_q[v]) begin
                if (phase_q[v] >= hp_q[v] - HP_W'(1)) begin
                    phase_d[v] = '0;
                    level_d[v] = ~level_q[v];
                end else begin
                    phase_d[v] = phase_q[v] + HP_W'(1);
                end
                rem_d[v] = rem_q[v] - RW'(1);
                if (rem_q[v] == RW'(1)) begin
                    active_d[v] = 1'b0;
                end else begin
                    active_d[v] = active_q[v];
                end
            end else begin
                active_d[v] = active_q[v];
            end
        end
    end

    // Mixer on pre-edge voice state, clamped to the unsigned 8-bit range
    always_comb begin
        sum_s = SW'(128);
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (active_q[v] && level_q[v]) begin
                sum_s = sum_s + SW'(AMP);
            end else if (active_q[v]) begin
                sum_s = sum_s - SW'(AMP);
            end else begin
                sum_s = sum_s;
            end
        end
        if (sum_s[SW-1]) begin
            mix_s = 8'd0;
        end else if (|sum_s[SW-2:8]) begin
            mix_s = 8'd255;
        end else begin
            mix_s = sum_s[7:0];
        end
        if (tick_s) begin
            audio_d = mix_s;
        end else begin
            audio_d = audio_q;
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            active_q <= '0;
            level_q  <= '0;
            audio_q  <= 8'd128;
            for (int v = 0; v < NUM_VOICES; v++) begin
                hp_q[v]    <= '0;
                phase_q[v] <= '0;
                rem_q[v]   <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            level_q  <= level_d;
            audio_q  <= audio_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                hp_q[v]    <= hp_d[v];
                phase_q[v] <= phase_d[v];
                rem_q[v]   <= rem_d[v];
            end
        end
    end

    assign req_ack_o      = win_oh_s;
    assign req_err_o      = reject_s ? win_oh_s : '0;
    assign voice_steal_o  = accept_s && !free_found_s;
    assign voice_active_o = active_q;
    assign sample_tick_o  = tick_s;
    assign audio_data_o   = audio_q;

endmodule

// File: tb/tb_lane_tone_scheduler.sv
// Directed bench for lane_tone_scheduler: SAMPLE_DIV=4, DUR_SAMPLES=8, two voices;
// a second instance with AMP=100 shares the stimulus to exercise mix clamping.
module tb_lane_tone_scheduler;

    localparam int NR = 4;
    localparam int NV = 2;
    localparam int HW = 12;

    logic           clk;
    logic           reset;
    logic [NR-1:0]  req;
    logic [NR*HW-1:0] hp_bus;

    logic [NR-1:0]  ack, err, ack2, err2;
    logic           steal, steal2, tick, tick2;
    logic [NV-1:0]  active, active2;
    logic [7:0]     audio, audio2;

    int n_cmp = 0;
    int n_mis = 0;
    int c     = 0;
    int exp_tone [8];

    lane_tone_scheduler #(.NUM_REQ(NR), .NUM_VOICES(NV), .SAMPLE_DIV(4), .DUR_SAMPLES(8),
                          .AMP(48), .HP_W(HW)) dut (
        .clk_i(clk), .reset_i(reset), .req_i(req), .half_period_i(hp_bus),
        .req_ack_o(ack), .req_err_o(err), .voice_steal_o(steal),
        .voice_active_o(active), .sample_tick_o(tick), .audio_data_o(audio));

    lane_tone_scheduler #(.NUM_REQ(NR), .NUM_VOICES(NV), .SAMPLE_DIV(4), .DUR_SAMPLES(8),
                          .AMP(100), .HP_W(HW)) dut_loud (
        .clk_i(clk), .reset_i(reset), .req_i(req), .half_period_i(hp_bus),
        .req_ack_o(ack2), .req_err_o(err2), .voice_steal_o(steal2),
        .voice_active_o(active2), .sample_tick_o(tick2), .audio_data_o(audio2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One cycle forward; cycle c (1 = first after reset release) ticks when c%4==0
    task automatic adv(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            c++;
            chk("tick", {31'd0, tick}, {31'd0, (c % 4 == 0)});
            chk("tick_loud", {31'd0, tick2}, {31'd0, (c % 4 == 0)});
        end
    endtask

    // Advance to the first cycle following a tick edge
    task automatic to_post_tick();
        do adv(1); while (c % 4 != 1);
    endtask

    task automatic set_hp(input int i, input logic [HW-1:0] v);
        hp_bus[i*HW +: HW] = v;
    endtask

    initial begin
        reset  = 1'b1;
        req    = '0;
        hp_bus = '0;
        exp_tone = '{176, 176, 80, 80, 176, 176, 80, 80};

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("rst_audio", audio, 32'd128);
        chk("rst_audio_loud", audio2, 32'd128);
        chk("rst_active", active, 32'd0);
        chk("rst_ack", ack, 32'd0);
        chk("rst_tick", tick, 32'd0);
        chk("rst_steal", steal, 32'd0);
        reset = 1'b0;
        c = 1;
        adv(12);
        chk("idle_audio", audio, 32'd128);
        chk("idle_ack", ack, 32'd0);

        // Single tone on requester 0, hp=2
        set_hp(0, 12'd2);
        req = 4'b0001;
        #1;
        chk("tone_ack", ack, 32'd1);
        chk("tone_err", err, 32'd0);
        chk("tone_steal", steal, 32'd0);
        adv(1);
        req = 4'b0000;
        #1;
        chk("tone_ack_drop", ack, 32'd0);
        chk("tone_active", active, 32'd1);
        chk("tone_audio_pre", audio, 32'd128);
        for (int k = 0; k < 8; k++) begin
            to_post_tick();
            chk("tone_audio", audio, exp_tone[k]);
        end
        chk("tone_expired", active, 32'd0);
        to_post_tick();
        chk("tone_silent", audio, 32'd128);

        // Simultaneous requests 2 and 1, both hp=3
        set_hp(1, 12'd3);
        set_hp(2, 12'd3);
        req = 4'b0110;
        #1;
        chk("sim_ack1", ack, 32'd2);
        chk("sim_ack1_loud", ack2, 32'd2);
        adv(1);
        req = 4'b0100;
        #1;
        chk("sim_ack2", ack, 32'd4);
        chk("sim_active1", active, 32'd1);
        adv(1);
        req = 4'b0000;
        #1;
        chk("sim_ack_none", ack, 32'd0);
        chk("sim_active2", active, 32'd3);
        to_post_tick();
        chk("sim_audio_hi", audio, 32'd224);
        chk("clamp_hi", audio2, 32'd255);
        repeat (3) to_post_tick();
        chk("sim_audio_lo", audio, 32'd32);
        chk("clamp_lo", audio2, 32'd0);
        repeat (4) to_post_tick();
        chk("sim_audio_last", audio, 32'd224);
        chk("sim_expired", active, 32'd0);
        chk("sim_expired_loud", active2, 32'd0);

        // Rejected request (hp=0)
        set_hp(0, 12'd0);
        req = 4'b0001;
        #1;
        chk("err_ack", ack, 32'd1);
        chk("err_err", err, 32'd1);
        chk("err_err_loud", err2, 32'd1);
        chk("err_steal", steal, 32'd0);
        adv(1);
        req = 4'b0000;
        #1;
        chk("err_no_voice", active, 32'd0);
        chk("err_err_drop", err, 32'd0);
        to_post_tick();
        chk("err_audio", audio, 32'd128);

        // Steal: voice0 (hp=1) at c=85, voice1 (hp=8) three ticks later, req3 two ticks after
        set_hp(0, 12'd1);
        req = 4'b0001;
        #1;
        chk("stl_v0_steal", steal, 32'd0);
        adv(1);
        req = 4'b0000;
        to_post_tick();
        chk("stl_v0_audio", audio, 32'd176);
        repeat (2) to_post_tick();
        set_hp(1, 12'd8);
        req = 4'b0010;
        #1;
        chk("stl_v1_ack", ack, 32'd2);
        chk("stl_v1_steal", steal, 32'd0);
        adv(1);
        req = 4'b0000;
        #1;
        chk("stl_both_active", active, 32'd3);
        to_post_tick();
        chk("stl_audio_mix", audio, 32'd128);
        to_post_tick();
        chk("stl_audio_pre", audio, 32'd224);
        set_hp(3, 12'd8);
        req = 4'b1000;
        #1;
        chk("stl_ack", ack, 32'd8);
        chk("stl_steal", steal, 32'd1);
        chk("stl_steal_loud", steal2, 32'd1);
        adv(1);
        req = 4'b0000;
        #1;
        chk("stl_steal_drop", steal, 32'd0);
        chk("stl_active", active, 32'd3);
        to_post_tick();
        chk("stl_reloaded", audio, 32'd224);
        repeat (5) to_post_tick();
        chk("stl_v1_done", active, 32'd1);
        chk("stl_v1_done_audio", audio, 32'd224);
        to_post_tick();
        chk("stl_v0_only", audio, 32'd176);
        chk("stl_v0_alive", active, 32'd1);
        to_post_tick();
        chk("stl_v0_last", audio, 32'd176);
        chk("stl_v0_done", active, 32'd0);
        to_post_tick();
        chk("stl_silent", audio, 32'd128);

        // Reset mid-tone with a pending request
        set_hp(0, 12'd2);
        req = 4'b0001;
        adv(1);
        req = 4'b0000;
        to_post_tick();
        chk("mid_audio", audio, 32'd176);
        chk("mid_active", active, 32'd1);
        adv(2);
        req = 4'b0001;
        reset = 1'b1;
        #1;
        chk("mid_rst_audio", audio, 32'd128);
        chk("mid_rst_active", active, 32'd0);
        chk("mid_rst_ack", ack, 32'd0);
        chk("mid_rst_tick", tick, 32'd0);
        repeat (2) @(negedge clk);
        chk("mid_rst_hold_ack", ack, 32'd0);
        req = 4'b0000;
        reset = 1'b0;
        c = 1;
        adv(3);
        chk("post_rst_audio", audio, 32'd128);
        adv(1);
        chk("post_rst_active", active, 32'd0);
        chk("post_rst_audio2", audio, 32'd128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
